// File: rtl/lamp_pkg.sv
// Shared defaults and sizing helper for the debounced staircase lamp controller.
package lamp_pkg;

    localparam int LAMP_N_SW            = 3;
    localparam int LAMP_DB_CYCLES       = 4;
    localparam int LAMP_AUTO_OFF_CYCLES = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchroniser followed by a stable-level debounce counter.
// s_db_d exposes the level S_db takes on the coming edge so the parent can see flips.
module sw_debounce
    import lamp_pkg::*;
#(
    parameter int DB_CYCLES = LAMP_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic s_raw,
    output logic s_db,
    output logic s_db_d
);

    localparam int            CW      = cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = s_raw;
        s2_d  = s1_q;
        db_d  = db_q;
        cnt_d = '0;
        // Any cycle where the synchronised level matches the stable one restarts the count.
        if (s2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign s_db   = db_q;
    assign s_db_d = db_d;

endmodule

// File: rtl/lamp_ctrl_n.sv
// N-way staircase lamp: debounced switches, lamp toggles on an odd number of flips.
// Define LAMP_AUTO_OFF_EN to add the idle timer that forces the lamp off.
module lamp_ctrl_n
    import lamp_pkg::*;
#(
    parameter int N_SW            = LAMP_N_SW,
    parameter int DB_CYCLES       = LAMP_DB_CYCLES,
    parameter int AUTO_OFF_CYCLES = LAMP_AUTO_OFF_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] S,
    output logic            F,
    output logic [N_SW-1:0] S_db,
    output logic            toggle,
    output logic            auto_off
);

    if (N_SW < 1 || DB_CYCLES < 1 || AUTO_OFF_CYCLES < 2) begin : g_bad_param
        $error("lamp_ctrl_n: parameter out of range");
    end

    logic [N_SW-1:0] db_q, db_d;

    for (genvar g = 0; g < N_SW; g++) begin : g_sw
        sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .s_raw  (S[g]),
            .s_db   (db_q[g]),
            .s_db_d (db_d[g])
        );
    end

    // Pairs of simultaneous flips cancel, so only the parity of the flip vector matters.
    logic evt;
    assign evt = ^(db_d ^ db_q);

    logic f_q, f_d;
    logic toggle_q, toggle_d;

`ifdef LAMP_AUTO_OFF_EN
    localparam int            TW   = cnt_w(AUTO_OFF_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(AUTO_OFF_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          auto_off_q, auto_off_d;

    always_comb begin
        f_d        = f_q ^ evt;
        toggle_d   = evt;
        timer_d    = '0;
        auto_off_d = 1'b0;
        // A switch event wins over a coincident timeout.
        if (!evt && f_q) begin
            if (timer_q == TMAX) begin
                f_d        = 1'b0;
                auto_off_d = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q    <= '0;
            auto_off_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            auto_off_q <= auto_off_d;
        end
    end

    assign auto_off = auto_off_q;
`else
    always_comb begin
        f_d      = f_q ^ evt;
        toggle_d = evt;
    end

    assign auto_off = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q      <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            f_q      <= f_d;
            toggle_q <= toggle_d;
        end
    end

    assign F      = f_q;
    assign S_db   = db_q;
    assign toggle = toggle_q;

endmodule

// File: tb/tb_lamp_ctrl_n.sv
// Directed bench for lamp_ctrl_n at default parameters; the timer scenarios run
// when LAMP_AUTO_OFF_EN is defined, the full switch walk when it is not.
module tb_lamp_ctrl_n;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] S;
    logic         F;
    logic [N-1:0] S_db;
    logic         toggle;
    logic         auto_off;

    int tests = 0;
    int fails = 0;

    lamp_ctrl_n #(.N_SW(N), .DB_CYCLES(4), .AUTO_OFF_CYCLES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .S        (S),
        .F        (F),
        .S_db     (S_db),
        .toggle   (toggle),
        .auto_off (auto_off)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic saw_tog;
        logic saw_ao;
        logic saw_db;

        rst = 1'b1;
        S   = '0;
        step(3);
        rst = 1'b0;
        step(1);
        chk1("rst_f", F, 1'b0);
        chkv("rst_sdb", S_db, 3'b000);
        chk1("rst_tog", toggle, 1'b0);
        chk1("rst_ao", auto_off, 1'b0);

        // idle with all switches off
        saw_tog = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (toggle === 1'b1) saw_tog = 1'b1;
        end
        chk1("idle_f", F, 1'b0);
        chkv("idle_sdb", S_db, 3'b000);
        chk1("idle_no_tog", saw_tog, 1'b0);

        // single clean flip: accepted on edge 6
        S = 3'b001;
        step(5);
        chkv("s0_e5_sdb", S_db, 3'b000);
        chk1("s0_e5_f", F, 1'b0);
        step(1);
        chkv("s0_e6_sdb", S_db, 3'b001);
        chk1("s0_e6_f", F, 1'b1);
        chk1("s0_e6_tog", toggle, 1'b1);
        step(1);
        chk1("s0_e7_tog", toggle, 1'b0);

        S = 3'b011;
        step(6);
        chk1("s1_f", F, 1'b0);
        chk1("s1_tog", toggle, 1'b1);
        step(1);

        S = 3'b111;
        step(6);
        chk1("s2_f", F, 1'b1);
        chkv("s2_sdb", S_db, 3'b111);
        step(1);

        // three bits drop together: odd count toggles
        S = 3'b000;
        step(6);
        chk1("drop3_f", F, 1'b0);
        chk1("drop3_tog", toggle, 1'b1);
        step(4);

        // glitch of 3 raw cycles is rejected
        S = 3'b001;
        step(3);
        S = 3'b000;
        saw_tog = 1'b0;
        saw_db  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (toggle === 1'b1) saw_tog = 1'b1;
            if (S_db !== 3'b000) saw_db = 1'b1;
        end
        chk1("glitch_no_db", saw_db, 1'b0);
        chk1("glitch_no_tog", saw_tog, 1'b0);
        chk1("glitch_f", F, 1'b0);

        // two simultaneous flips cancel
        S = 3'b011;
        saw_tog = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (toggle === 1'b1) saw_tog = 1'b1;
        end
        chkv("pair_sdb", S_db, 3'b011);
        chk1("pair_f", F, 1'b0);
        chk1("pair_no_tog", saw_tog, 1'b0);
        step(2);
        S = 3'b111;
        step(6);
        chk1("pair_then_f", F, 1'b1);
        chk1("pair_then_tog", toggle, 1'b1);
        step(1);
        S = 3'b000;
        step(6);
        chk1("back0_f", F, 1'b0);
        step(4);

`ifdef LAMP_AUTO_OFF_EN
        // lamp on, then idle until the timer forces it off
        S = 3'b001;
        step(6);
        chk1("ao_on_f", F, 1'b1);
        chk1("ao_on_tog", toggle, 1'b1);
        saw_ao = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (auto_off === 1'b1) saw_ao = 1'b1;
        end
        chk1("ao_pre_f", F, 1'b1);
        chk1("ao_pre_none", saw_ao, 1'b0);
        step(1);
        chk1("ao_fire_f", F, 1'b0);
        chk1("ao_fire_pulse", auto_off, 1'b1);
        chk1("ao_fire_tog", toggle, 1'b0);
        step(1);
        chk1("ao_after_pulse", auto_off, 1'b0);
        step(10);
        chk1("ao_hold_f", F, 1'b0);

        // next flip turns the lamp back on despite XOR of switches being 0
        S = 3'b000;
        step(6);
        chk1("ao_relight_f", F, 1'b1);
        chk1("ao_relight_tog", toggle, 1'b1);

        // flip accepted exactly on the timeout edge
        step(10);
        S = 3'b001;
        step(5);
        chk1("ao_race_pre_f", F, 1'b1);
        step(1);
        chk1("ao_race_f", F, 1'b0);
        chk1("ao_race_tog", toggle, 1'b1);
        chk1("ao_race_ao", auto_off, 1'b0);
        step(1);
        chk1("ao_race_ao_next", auto_off, 1'b0);
        S = 3'b000;
        step(6);
        chk1("ao_race_relight", F, 1'b1);
`else
        // walk every switch pattern; lamp follows XOR of the debounced levels
        saw_ao = 1'b0;
        for (int v = 0; v < 8; v++) begin
            logic [N-1:0] vv;
            vv = N'(v);
            S  = vv;
            for (int i = 0; i < 10; i++) begin
                step(1);
                if (auto_off === 1'b1) saw_ao = 1'b1;
            end
            chkv("walk_sdb", S_db, vv);
            chk1("walk_f", F, ^vv);
        end
        chk1("walk_no_ao", saw_ao, 1'b0);
`endif

        // asynchronous reset away from any clock edge, then recovery
        chk1("pre_rst_f", F, 1'b1);
        S = 3'b100;
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_f", F, 1'b0);
        chkv("arst_sdb", S_db, 3'b000);
        chk1("arst_tog", toggle, 1'b0);
        chk1("arst_ao", auto_off, 1'b0);
        #2;
        rst = 1'b0;
        step(5);
        chkv("post_rst_e5_sdb", S_db, 3'b000);
        step(1);
        chkv("post_rst_sdb", S_db, 3'b100);
        chk1("post_rst_f", F, 1'b1);
        chk1("post_rst_tog", toggle, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
